// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, decides taken/mispredict and the redirect PC, with a one-entry output register.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             BrEq,
  output logic             BrLT,
  output logic             taken,
  output logic             illegal,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
`endif
);

  // state   | meaning
  // S_EMPTY | no result held, out_valid=0
  // S_FULL  | result held in output register, out_valid=1
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t r_state, w_state_nxt;

  logic             w_capture;
  logic             w_eq;
  logic             w_lt;
  logic             w_illegal;
  logic             w_taken;
  logic             w_mispredict;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_fall;

  logic             r_breq;
  logic             r_brlt;
  logic             r_taken;
  logic             r_illegal;
  logic             r_mispredict;
  logic [WIDTH-1:0] r_redirect_pc;

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_capture = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_capture) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready && !w_capture) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Unsigned compare only for BLTU/BGEU; every other encoding uses signed.
  assign w_eq = (operand_0 == operand_1);
  assign w_lt = (funct3[2:1] == 2'b11) ? (operand_0 < operand_1)
                                       : ($signed(operand_0) < $signed(operand_1));
  assign w_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:          w_taken = w_eq;
      3'b001:          w_taken = !w_eq;
      3'b100, 3'b110:  w_taken = w_lt;
      3'b101, 3'b111:  w_taken = !w_lt;
      default:         w_taken = 1'b0;
    endcase
  end

  assign w_mispredict = !w_illegal && (w_taken ^ pred_taken);
  assign w_target     = pc + imm;
  assign w_fall       = pc + WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_breq        <= 1'b0;
      r_brlt        <= 1'b0;
      r_taken       <= 1'b0;
      r_illegal     <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else if (w_capture) begin
      r_breq        <= w_eq;
      r_brlt        <= w_lt;
      r_taken       <= w_taken;
      r_illegal     <= w_illegal;
      r_mispredict  <= w_mispredict;
      r_redirect_pc <= w_taken ? w_target : w_fall;
    end
  end

  assign BrEq        = r_breq;
  assign BrLT        = r_brlt;
  assign taken       = r_taken;
  assign illegal     = r_illegal;
  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mispred_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (stats_clr) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_capture && !w_illegal) begin
      if (r_br_count != '1)                     r_br_count      <= r_br_count + 1'b1;
      if (w_mispredict && r_mispred_count != '1) r_mispred_count <= r_mispred_count + 1'b1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized traffic against a queue-based reference model.
// Define BRANCH_STATS_EN to also check the statistics counters (built with CNT_W=2).
module tb_branch_resolve_unit;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_0, operand_1, pc, imm;
  logic [2:0]       funct3;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             BrEq, BrLT, taken, illegal, mispredict;
  logic [WIDTH-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] br_count, mispred_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        eq;
    logic        lt;
    logic        tk;
    logic        ill;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   m_br  = 0;
  int   m_mis = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_0(operand_0), .operand_1(operand_1), .funct3(funct3),
    .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .BrEq(BrEq), .BrLT(BrLT), .taken(taken), .illegal(illegal),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stats_clr(stats_clr), .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im, input logic pr);
    exp_t e;
    int   sa, sb;
    sa    = a;
    sb    = b;
    e.eq  = (a == b);
    e.lt  = (f == 3'd6 || f == 3'd7) ? (a < b) : (sa < sb);
    e.ill = (f == 3'd2 || f == 3'd3);
    if (f == 3'd0)                    e.tk = e.eq;
    else if (f == 3'd1)               e.tk = !e.eq;
    else if (f == 3'd4 || f == 3'd6)  e.tk = e.lt;
    else if (f == 3'd5 || f == 3'd7)  e.tk = !e.lt;
    else                              e.tk = 1'b0;
    e.mis = e.ill ? 1'b0 : (e.tk ^ pr);
    e.rpc = e.tk ? p + im : p + 32'd4;
    return e;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im, input logic pr);
    funct3 = f; operand_0 = a; operand_1 = b; pc = p; imm = im; pred_taken = pr;
  endtask

  // One clock: predict capture/drain from current inputs, advance, then check outputs.
  task automatic step();
    bit   cap, drn, clr;
    exp_t e;
    cap = in_valid && (q.size() == 0 || out_ready);
    drn = (q.size() != 0) && out_ready;
    e   = model(funct3, operand_0, operand_1, pc, imm, pred_taken);
`ifdef BRANCH_STATS_EN
    clr = stats_clr;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (drn) void'(q.pop_front());
    if (cap) q.push_back(e);
    if (clr) begin
      m_br = 0; m_mis = 0;
    end else if (cap && !e.ill) begin
      if (m_br < CNT_MAX) m_br++;
      if (e.mis && m_mis < CNT_MAX) m_mis++;
    end
    total++;
    if (out_valid !== (q.size() != 0)) begin
      bad++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() != 0);
    end
    total++;
    if (in_ready !== (q.size() == 0 || out_ready)) begin
      bad++; $display("FAIL in_ready: got %b want %b", in_ready, q.size() == 0 || out_ready);
    end
    if (q.size() != 0) begin
      total++;
      if ({BrEq, taken, illegal, mispredict, redirect_pc} !== {q[0].eq, q[0].tk, q[0].ill, q[0].mis, q[0].rpc}) begin
        bad++;
        $display("FAIL result: got eq=%b tk=%b ill=%b mis=%b rpc=%h want eq=%b tk=%b ill=%b mis=%b rpc=%h",
                 BrEq, taken, illegal, mispredict, redirect_pc,
                 q[0].eq, q[0].tk, q[0].ill, q[0].mis, q[0].rpc);
      end
      if (!q[0].ill) begin
        total++;
        if (BrLT !== q[0].lt) begin
          bad++; $display("FAIL BrLT: got %b want %b", BrLT, q[0].lt);
        end
      end
    end
`ifdef BRANCH_STATS_EN
    total++;
    if (br_count !== CNT_W'(m_br) || mispred_count !== CNT_W'(m_mis)) begin
      bad++; $display("FAIL counters: got br=%0d mis=%0d want br=%0d mis=%0d", br_count, mispred_count, m_br, m_mis);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({out_valid, BrEq, BrLT, taken, illegal, mispredict, redirect_pc} !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_state: got ov=%b rdy=%b rpc=%h want ov=0 rdy=1 rpc=0", out_valid, in_ready, redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(3'b000, 32'd100, 32'd100, 32'h1000, 32'h20, 1'b0);
    step();
    total++;
    if ({out_valid, BrEq, taken, mispredict, redirect_pc} !== {1'b1, 1'b1, 1'b1, 1'b1, 32'h1020}) begin
      bad++; $display("FAIL beq: got ov=%b eq=%b tk=%b mis=%b rpc=%h want 1 1 1 1 00001020", out_valid, BrEq, taken, mispredict, redirect_pc);
    end
    drive(3'b100, 32'hFFFF_FFF6, 32'd5, 32'h2000, 32'h40, 1'b1);
    step();
    total++;
    if ({BrLT, taken, redirect_pc} !== {1'b1, 1'b1, 32'h2040}) begin
      bad++; $display("FAIL blt: got lt=%b tk=%b rpc=%h want 1 1 00002040", BrLT, taken, redirect_pc);
    end
    drive(3'b110, 32'hFFFF_FFF6, 32'd5, 32'h2000, 32'h40, 1'b1);
    step();
    total++;
    if ({BrLT, taken, redirect_pc} !== {1'b0, 1'b0, 32'h2004}) begin
      bad++; $display("FAIL bltu: got lt=%b tk=%b rpc=%h want 0 0 00002004", BrLT, taken, redirect_pc);
    end
    drive(3'b101, 32'd200, 32'd100, 32'hFFFF_FFFC, 32'd8, 1'b1);
    step();
    total++;
    if ({taken, mispredict, redirect_pc} !== {1'b1, 1'b0, 32'h4}) begin
      bad++; $display("FAIL bge_wrap: got tk=%b mis=%b rpc=%h want 1 0 00000004", taken, mispredict, redirect_pc);
    end
    drive(3'b010, 32'd7, 32'd7, 32'h3000, 32'h10, 1'b1);
    step();
    total++;
    if ({illegal, taken, mispredict, redirect_pc} !== {1'b1, 1'b0, 1'b0, 32'h3004}) begin
      bad++; $display("FAIL illegal: got ill=%b tk=%b mis=%b rpc=%h want 1 0 0 00003004", illegal, taken, mispredict, redirect_pc);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(3'b001, 32'd1, 32'd2, 32'h4000, 32'h100, 1'b0);
    step();
    out_ready = 1'b0;
    drive(3'b000, 32'd9, 32'd9, 32'h5000, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || redirect_pc !== 32'h4100 || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_%0d: got rdy=%b ov=%b rpc=%h want 0 1 00004100", i, in_ready, out_valid, redirect_pc);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || redirect_pc !== 32'h5080) begin
      bad++; $display("FAIL resume: got ov=%b rpc=%h want 1 00005080", out_valid, redirect_pc);
    end
    drive(3'b111, 32'd3, 32'd4, 32'h6000, 32'h8, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1 || redirect_pc !== 32'h6004) begin
      bad++; $display("FAIL no_bubble: got ov=%b rpc=%h want 1 00006004", out_valid, redirect_pc);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      if ($urandom_range(0, 1) != 0) a = $urandom_range(0, 20) - 10;
      drive(3'($urandom_range(0, 7)), a,
            ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 20) - 10) : $urandom),
            $urandom, 32'($urandom_range(0, 4096) - 2048), 1'($urandom_range(0, 1)));
`ifdef BRANCH_STATS_EN
      stats_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end
`ifdef BRANCH_STATS_EN
    stats_clr = 1'b0;
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midcycle();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(3'b000, 32'd5, 32'd5, 32'h7000, 32'h40, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_pc !== '0 || taken !== 1'b0) begin
      bad++; $display("FAIL midcycle_reset: got ov=%b rdy=%b rpc=%h tk=%b want 0 1 0 0", out_valid, in_ready, redirect_pc, taken);
    end
    q.delete();
    m_br = 0; m_mis = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    step();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats_sat();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 32'(i), 32'(i), 32'h100, 32'h10, 1'b0);
      step();
    end
    in_valid = 1'b0;
    step();
    total++;
    if (mispred_count !== 2'd3 || br_count !== 2'd3) begin
      bad++; $display("FAIL stats_sat: got br=%0d mis=%0d want 3 3", br_count, mispred_count);
    end
    stats_clr = 1'b1; in_valid = 1'b1;
    step();
    stats_clr = 1'b0; in_valid = 1'b0;
    total++;
    if (br_count !== 2'd0 || mispred_count !== 2'd0) begin
      bad++; $display("FAIL stats_clr: got br=%0d mis=%0d want 0 0", br_count, mispred_count);
    end
  endtask
`endif

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    drive(3'b000, '0, '0, '0, '0, 1'b0);
`ifdef BRANCH_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midcycle();
`ifdef BRANCH_STATS_EN
    test_stats_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, PC and immediate width (>= 8).
REQ-002 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  request valid.
REQ-007 in_ready  out  1  unit can accept request.
REQ-008 operand_0, operand_1  in  WIDTH each  values compared (rs1, rs2).
REQ-009 funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 pc, imm  in  WIDTH each  branch PC; sign-extended byte offset.
REQ-011 pred_taken  in  1  front-end prediction.
REQ-012 out_valid  in/out: out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-013 BrEq, BrLT, taken, illegal, mispredict  out  1 each  registered results.
REQ-014 redirect_pc  out  WIDTH  correct next PC.
REQ-015 stats_clr  in  1; br_count, mispred_count  out  CNT_W each (present only with BRANCH_STATS_EN).

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL capture a request on a rising edge where in_valid && in_ready; results appear one cycle later with out_valid=1.
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid on out_ready without a new capture; back-to-back capture and drain in the same cycle SHALL sustain one result per cycle.
REQ-020 Output state: EMPTY (out_valid=0) -> FULL on capture; FULL -> EMPTY on out_ready with no capture; FULL -> FULL on out_ready with capture (outputs replaced).
REQ-021 BrEq SHALL equal (operand_0 == operand_1).
REQ-022 BrLT SHALL be the signed compare for funct3 100/101, unsigned for 110/111; for 000/001 it SHALL be the signed compare.
REQ-023 taken SHALL be BrEq (000), !BrEq (001), BrLT (100/110), !BrLT (101/111).
REQ-024 funct3 010 or 011 SHALL set illegal=1, taken=0, mispredict=0, redirect_pc=pc+4.
REQ-025 target SHALL be (pc + imm) mod 2^WIDTH; fall-through SHALL be (pc + 4) mod 2^WIDTH.
REQ-026 redirect_pc SHALL be target when taken, else fall-through.
REQ-027 mispredict SHALL be taken XOR pred_taken for legal funct3.

Reset
REQ-028 rst_n low SHALL immediately clear out_valid, BrEq, BrLT, taken, illegal, mispredict, redirect_pc and counters to 0, independent of clk.
REQ-029 A request held in the output register when reset asserts SHALL be discarded; in_ready SHALL be 1 while rst_n is low.
REQ-030 First capture SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro BRANCH_STATS_EN SHALL enable statistics.
REQ-032 With it: br_count SHALL increment per legal capture, mispred_count per captured mispredict, both saturating at 2^CNT_W-1; stats_clr SHALL zero both synchronously, taking priority over increment.
REQ-033 Without it: stats_clr, br_count, mispred_count ports and counter logic SHALL be absent; other behaviour identical.

Verification
REQ-034 BEQ, operand_0=operand_1=100, pc=0x1000, imm=0x20, pred_taken=0 -> next cycle out_valid=1, BrEq=1, taken=1, mispredict=1, redirect_pc=0x1020.
REQ-035 BLT, operand_0=0xFFFFFFF6 (-10), operand_1=5 -> BrLT=1, taken=1; same operands BLTU -> BrLT=0, taken=0, redirect_pc=pc+4.
REQ-036 BGE, operand_0=200, operand_1=100, pc=0xFFFFFFFC, imm=8 -> taken=1, redirect_pc=0x00000004 (wrap).
REQ-037 funct3=010 -> illegal=1, taken=0, mispredict=0, br_count unchanged.
REQ-038 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 with new request -> next result in following cycle, no bubble.
REQ-039 rst_n pulsed low mid-cycle with out_valid=1 -> out_valid=0 before next edge; with BRANCH_STATS_EN, CNT_W=2, 5 mispredicted branches -> mispred_count=3.
